// File: rtl/spi_pkg.sv
// Shared definitions for the SPI responder.
//
// Contents:
//   SPI_MODE0..SPI_MODE3  mode constants encoded as {cpol, cpha}
//   clog2()               ceiling log2, used to size the bit counter
//   spi_state_e           responder FSM state encoding
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  // Smallest r with 2**r >= value; the counter must hold 0..8*NBYTES, so callers pass
  // 8*NBYTES+1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // StDone is only reachable in single-frame builds: the frame is complete and further
  // sclk edges are ignored until CS deasserts.
  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDone
  } spi_state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchroniser for one asynchronous SPI pin, followed by an edge-detect
// register. rise/fall are asserted for one clk cycle when the synchronised level changes.
//
// Ports:
//   clk       system clock
//   rst_n     synchronous reset, active low; all stages load idle_val
//   idle_val  level the pin is assumed to sit at while in reset
//   async_in  asynchronous pin
//   rise      synchronised 0->1 transition (one cycle)
//   fall      synchronised 1->0 transition (one cycle)
//
// A pin change becomes visible on rise/fall Stages clk edges later, so logic registering
// on rise/fall acts Stages+1 edges after the pin moved.
module spi_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic idle_val,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic [Stages-1:0] stage_q;
  logic              prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= {Stages{idle_val}};
      prev_q  <= idle_val;
    end else begin
      stage_q <= {stage_q[Stages-2:0], async_in};
      prev_q  <= stage_q[Stages-1];
    end
  end

  assign rise = stage_q[Stages-1] & ~prev_q;
  assign fall = ~stage_q[Stages-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder running on an oversampling system clock (clk >= 8x sclk).
//
// Ports:
//   clk, rst_n         system clock, synchronous active-low reset
//   cpol, cpha         SPI mode, captured when CS falls
//   sclk, cs_n, mosi   asynchronous SPI pins from the master
//   miso, miso_oe      data to master and its tri-state enable
//   din                word transmitted MSB first, latched at frame start
//   dout, dout_valid   last complete received word and its one-cycle strobe
//   busy               high while the synchronised CS is active
//   abort              one-cycle pulse when CS deasserts part-way through a frame
//
// Build option: SPI_SLAVE_MULTIFRAME_EN allows back-to-back frames within one CS window;
// without it, edges after a full frame are ignored and miso holds 0.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned NBYTES      = 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cpol,
  input  logic                cpha,
  input  logic                sclk,
  input  logic                cs_n,
  input  logic                mosi,
  output logic                miso,
  output logic                miso_oe,
  input  logic [8*NBYTES-1:0] din,
  output logic [8*NBYTES-1:0] dout,
  output logic                dout_valid,
  output logic                busy,
  output logic                abort
);

  localparam int unsigned NBITS = 8 * NBYTES;
  localparam int unsigned CntW  = clog2(NBITS + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(NBITS);

  // Synchronised pin events
  logic sclk_rise, sclk_fall;
  logic cs_rise, cs_fall;
  logic mosi_s;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  spi_sync #(
    .Stages(SYNC_STAGES)
  ) u_sclk_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .idle_val (cpol),
    .async_in (sclk),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  spi_sync #(
    .Stages(SYNC_STAGES)
  ) u_cs_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .idle_val (1'b1),
    .async_in (cs_n),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  // mosi needs no edge detect; same depth keeps it aligned with the sclk edge that samples it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
    end
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // State
  spi_state_e       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [NBITS-1:0] tx_q, tx_d;
  logic [NBITS-1:0] rx_q, rx_d;
  logic [NBITS-1:0] dout_q, dout_d;
  logic             miso_q, miso_d;
  logic             oe_q, oe_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             abort_q, abort_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;

  // Edges relative to the idle level captured at frame start
  logic leading, trailing;
  assign leading  = cpol_q ? sclk_fall : sclk_rise;
  assign trailing = cpol_q ? sclk_rise : sclk_fall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    dout_d  = dout_q;
    miso_d  = miso_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    abort_d = 1'b0;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;

    case (state_q)
      StIdle: begin
        // sclk edges in this cycle are dropped: CS takes priority.
        if (cs_fall) begin
          state_d = StActive;
          tx_d    = din;
          cnt_d   = '0;
          busy_d  = 1'b1;
          oe_d    = 1'b1;
          cpol_d  = cpol;
          cpha_d  = cpha;
          miso_d  = cpha ? 1'b0 : din[NBITS-1];
        end
      end

      StActive: begin
        if (cnt_q == CntFull) begin
          dout_d  = rx_q;
          valid_d = 1'b1;
`ifdef SPI_SLAVE_MULTIFRAME_EN
          tx_d  = din;
          cnt_d = '0;
          if (!cpha_q) begin
            miso_d = din[NBITS-1];
          end
`else
          state_d = StDone;
          miso_d  = 1'b0;
`endif
        end else if (!cpha_q) begin
          if (leading) begin
            rx_d  = {rx_q[NBITS-2:0], mosi_s};
            cnt_d = cnt_q + CntW'(1);
          end else if (trailing && cnt_q != '0) begin
            // cnt==0 here can only be the trailing edge of the previous frame's last bit
            // after a multiframe reload; shifting would lose the new MSB.
            tx_d   = tx_q << 1;
            miso_d = tx_q[NBITS-2];
          end
        end else begin
          if (leading) begin
            miso_d = tx_q[NBITS-1];
            tx_d   = tx_q << 1;
          end else if (trailing) begin
            rx_d  = {rx_q[NBITS-2:0], mosi_s};
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      StDone: begin
        miso_d = 1'b0;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_q != StIdle && cs_rise) begin
      state_d = StIdle;
      busy_d  = 1'b0;
      oe_d    = 1'b0;
      miso_d  = 1'b0;
      abort_d = (cnt_q != '0) && (cnt_q != CntFull);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      miso_q  <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      abort_q <= 1'b0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      miso_q  <= miso_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      abort_q <= abort_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
    end
  end

  assign miso       = miso_q;
  assign miso_oe    = oe_q;
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign abort      = abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a behavioural SPI master drives one NBYTES=1 and one NBYTES=2
// responder (separate chip selects, shared sclk/mosi) at sclk = clk/8.
module tb_spi_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpol = 1'b0;
  logic        cpha = 1'b0;
  logic        sclk = 1'b0;
  logic        cs8_n = 1'b1;
  logic        cs16_n = 1'b1;
  logic        mosi = 1'b0;
  logic [7:0]  din8 = 8'h00;
  logic [15:0] din16 = 16'h0000;
  logic        miso8, miso_oe8, dout_valid8, busy8, abort8;
  logic        miso16, miso_oe16, dout_valid16, busy16, abort16;
  logic [7:0]  dout8;
  logic [15:0] dout16;

  always #5 clk = ~clk;

  spi_slave #(.NBYTES(1), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .sclk(sclk), .cs_n(cs8_n),
    .mosi(mosi), .miso(miso8), .miso_oe(miso_oe8), .din(din8), .dout(dout8),
    .dout_valid(dout_valid8), .busy(busy8), .abort(abort8)
  );

  spi_slave #(.NBYTES(2), .SYNC_STAGES(2)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .sclk(sclk), .cs_n(cs16_n),
    .mosi(mosi), .miso(miso16), .miso_oe(miso_oe16), .din(din16), .dout(dout16),
    .dout_valid(dout_valid16), .busy(busy16), .abort(abort16)
  );

  int errors = 0;
  int checks = 0;

  // Pulse monitors, sampled away from the active edge
  int valid8_n = 0, abort8_n = 0, valid16_n = 0, abort16_n = 0;
  logic [7:0] dout_log8 [$];

  always @(negedge clk) begin
    if (dout_valid8) begin
      valid8_n++;
      dout_log8.push_back(dout8);
    end
    if (abort8) abort8_n++;
    if (dout_valid16) valid16_n++;
    if (abort16) abort16_n++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic half_period();
    repeat (4) @(negedge clk);
  endtask

  // Behavioural master: nbits bits of word, MSB first; returns the miso bits it sampled.
  task automatic spi_xfer(input bit wide, input logic [1:0] mode, input logic [31:0] word,
                          input int nbits, output logic [31:0] rx);
    rx = '0;
    @(negedge clk);
    cpol = mode[1];
    cpha = mode[0];
    sclk = mode[1];
    repeat (6) @(negedge clk);
    if (wide) cs16_n = 1'b0;
    else cs8_n = 1'b0;
    if (!mode[0]) mosi = word[nbits-1];
    half_period();
    for (int i = 0; i < nbits; i++) begin
      if (mode[0]) mosi = word[nbits-1-i];
      else rx = {rx[30:0], (wide ? miso16 : miso8)};
      sclk = ~mode[1];
      half_period();
      if (mode[0]) rx = {rx[30:0], (wide ? miso16 : miso8)};
      sclk = mode[1];
      if (!mode[0] && (i + 1 < nbits)) mosi = word[nbits-2-i];
      half_period();
    end
    if (wide) cs16_n = 1'b1;
    else cs8_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Reference model: after a full frame the responder holds the last 8*NBYTES bits the
  // master sent, and the master has received the responder's din.
  function automatic logic [31:0] model_dout(input logic [31:0] word, input int nbytes);
    logic [31:0] mask;
    mask = (32'd1 << (8 * nbytes)) - 32'd1;
    return word & mask;
  endfunction

  typedef struct {
    logic [1:0] mode;
    logic [7:0] din;
    logic [7:0] mosi_word;
    logic [7:0] exp_dout;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs [4];
  logic [31:0] rx;
  int v0, a0, v16, a16;
  logic [7:0] r_din;
  logic [31:0] r_word;
  logic [1:0] r_mode;

  initial begin
    vecs[0] = '{2'd1, 8'h81, 8'h7E, 8'h7E, 8'h81};
    vecs[1] = '{2'd2, 8'h81, 8'h7E, 8'h7E, 8'h81};
    vecs[2] = '{2'd3, 8'h81, 8'h7E, 8'h7E, 8'h81};
    vecs[3] = '{2'd0, 8'hA5, 8'h3C, 8'h3C, 8'hA5};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst miso", miso8, 0);
    check("rst miso_oe", miso_oe8, 0);
    check("rst dout", dout8, 0);
    check("rst dout_valid", dout_valid8, 0);
    check("rst busy", busy8, 0);
    check("rst abort", abort8, 0);
    check("rst dout16", dout16, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("post-rst busy", busy8, 0);

    // Table-driven: one frame per mode
    for (int i = 0; i < 4; i++) begin
      din8 = vecs[i].din;
      v0 = valid8_n;
      a0 = abort8_n;
      spi_xfer(1'b0, vecs[i].mode, {24'd0, vecs[i].mosi_word}, 8, rx);
      check($sformatf("vec%0d dout", i), dout8, vecs[i].exp_dout);
      check($sformatf("vec%0d master rx", i), rx, vecs[i].exp_rx);
      check($sformatf("vec%0d valid pulses", i), valid8_n - v0, 1);
      check($sformatf("vec%0d abort pulses", i), abort8_n - a0, 0);
      check($sformatf("vec%0d miso_oe idle", i), miso_oe8, 0);
    end

    // CS released after 5 bits
    din8 = 8'hA5;
    v0 = valid8_n;
    a0 = abort8_n;
    spi_xfer(1'b0, 2'd0, 32'h15, 5, rx);
    check("abort pulses", abort8_n - a0, 1);
    check("abort valid pulses", valid8_n - v0, 0);
    check("abort dout kept", dout8, 8'h3C);
    check("abort busy", busy8, 0);
    check("abort miso_oe", miso_oe8, 0);
    check("abort miso", miso8, 0);

    // Two-byte frame
    din16 = 16'hBEEF;
    v0 = valid8_n;
    v16 = valid16_n;
    a16 = abort16_n;
    spi_xfer(1'b1, 2'd0, 32'h1234, 16, rx);
    check("nb2 dout", dout16, 16'h1234);
    check("nb2 master rx", rx, 16'hBEEF);
    check("nb2 valid pulses", valid16_n - v16, 1);
    check("nb2 abort pulses", abort16_n - a16, 0);
    check("nb2 other dut quiet", valid8_n - v0, 0);

    // Reset in the middle of a frame (after bit 3)
    din8 = 8'hC3;
    @(negedge clk);
    cpol = 1'b0;
    cpha = 1'b0;
    sclk = 1'b0;
    repeat (6) @(negedge clk);
    cs8_n = 1'b0;
    mosi = 1'b1;
    half_period();
    for (int i = 0; i < 3; i++) begin
      sclk = 1'b1;
      half_period();
      sclk = 1'b0;
      half_period();
    end
    check("midframe busy", busy8, 1);
    check("midframe miso_oe", miso_oe8, 1);
    a0 = abort8_n;
    rst_n = 1'b0;
    cs8_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst miso", miso8, 0);
    check("midrst miso_oe", miso_oe8, 0);
    check("midrst dout", dout8, 0);
    check("midrst busy", busy8, 0);
    check("midrst dout_valid", dout_valid8, 0);
    repeat (10) @(negedge clk);
    check("midrst abort pulses", abort8_n - a0, 0);
    v0 = valid8_n;
    spi_xfer(1'b0, 2'd0, 32'h55, 8, rx);
    check("after rst dout", dout8, 8'h55);
    check("after rst master rx", rx, 8'hC3);
    check("after rst valid pulses", valid8_n - v0, 1);
    check("after rst abort pulses", abort8_n - a0, 0);

    // Randomised frames against the reference model
    for (int i = 0; i < 12; i++) begin
      r_mode = 2'($urandom_range(0, 3));
      r_din = 8'($urandom);
      r_word = $urandom;
      din8 = r_din;
      v0 = valid8_n;
      a0 = abort8_n;
      spi_xfer(1'b0, r_mode, r_word, 8, rx);
      check($sformatf("rnd%0d m%0d dout", i, r_mode), dout8, model_dout(r_word, 1));
      check($sformatf("rnd%0d m%0d rx", i, r_mode), rx, r_din);
      check($sformatf("rnd%0d valid", i), valid8_n - v0, 1);
      check($sformatf("rnd%0d abort", i), abort8_n - a0, 0);
    end
    for (int i = 0; i < 3; i++) begin
      r_mode = 2'($urandom_range(0, 3));
      r_word = $urandom;
      din16 = 16'($urandom);
      spi_xfer(1'b1, r_mode, r_word, 16, rx);
      check($sformatf("rnd16_%0d m%0d dout", i, r_mode), dout16, model_dout(r_word, 2));
      check($sformatf("rnd16_%0d rx", i), rx, {16'd0, din16});
    end

    // 16 bits within one CS window on the one-byte responder
    for (int m = 0; m < 4; m += 3) begin
      din8 = 8'h5A;
      v0 = valid8_n;
      a0 = abort8_n;
      spi_xfer(1'b0, 2'(m), 32'h1122, 16, rx);
      check($sformatf("mf m%0d abort", m), abort8_n - a0, 0);
`ifdef SPI_SLAVE_MULTIFRAME_EN
      check($sformatf("mf m%0d valid pulses", m), valid8_n - v0, 2);
      if (dout_log8.size() >= 2) begin
        check($sformatf("mf m%0d first dout", m), dout_log8[dout_log8.size()-2], 8'h11);
        check($sformatf("mf m%0d second dout", m), dout_log8[dout_log8.size()-1], 8'h22);
      end
      check($sformatf("mf m%0d master rx", m), rx, 16'h5A5A);
`else
      check($sformatf("mf m%0d valid pulses", m), valid8_n - v0, 1);
      check($sformatf("mf m%0d dout", m), dout8, 8'h11);
      check($sformatf("mf m%0d master rx", m), rx, 16'h5A00);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
